// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame constants and baud helpers for the UART blocks
package uart_pkg;
   localparam int DATA_BITS = 8;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   function automatic int tick_div(input int clk_freq, input int baud, input int oversample);
      int d;
      d = clk_freq / (baud * oversample);
      return (d < 1) ? 1 : d;
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk into one-cycle sample ticks, with a synchronous restart that re-aligns the phase
module uart_baud_tick #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);
   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = !restart && (cnt == W'(TICK_DIV - 1));
   // free-running divider, held at zero while restart is high
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else if (restart || tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 receiver with oversampling, 3-sample majority vote, glitch rejection and framing-error report
module uart_rx_oversample import uart_pkg::*; #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rxd_data,
   output logic                 rxd_data_ready,
   output logic                 rxd_frame_err,
   output logic                 rxd_busy
);
   localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] MID_LO = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] MID    = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] MID_HI = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] LAST   = SW'(OVERSAMPLE - 1);
   state_t state, state_nx;
   logic sync1, sync2, prev;
   logic [SW-1:0] samp_cnt, samp_cnt_nx;
   logic [BW-1:0] bit_cnt, bit_cnt_nx;
   logic [DATA_BITS-1:0] shift, shift_nx, data_nx;
   logic [1:0] votes, votes_nx;
   logic ready_nx, err_nx, tick, maj, decide, bit_end;
   uart_baud_tick #(.TICK_DIV(TICK_DIV)) baud (
      .clk(clk),
      .reset(reset),
      .restart(state == IDLE),
      .tick(tick)
   );
   assign maj      = (votes[0] & votes[1]) | (votes[0] & sync2) | (votes[1] & sync2);
   assign decide   = tick && samp_cnt == MID_HI;
   assign bit_end  = tick && samp_cnt == LAST;
   assign rxd_busy = state != IDLE;
   // next-state: sample counting, vote capture, bit assembly and frame decisions
   always_comb begin
      state_nx    = state;
      samp_cnt_nx = samp_cnt;
      bit_cnt_nx  = bit_cnt;
      shift_nx    = shift;
      votes_nx    = votes;
      data_nx     = rxd_data;
      ready_nx    = 1'b0;
      err_nx      = 1'b0;
      if (tick) begin
         samp_cnt_nx = (samp_cnt == LAST) ? '0 : samp_cnt + 1'b1;
         if (samp_cnt == MID_LO) votes_nx[0] = sync2;
         if (samp_cnt == MID) votes_nx[1] = sync2;
      end
      case (state)
         IDLE:
            if (prev && !sync2) begin
               state_nx    = START;
               samp_cnt_nx = '0;
               bit_cnt_nx  = '0;
            end
         START:
            if (decide && maj) state_nx = IDLE;
            else if (bit_end) state_nx = DATA;
         DATA: begin
            if (decide) shift_nx = {maj, shift[DATA_BITS-1:1]};
            if (bit_end) begin
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == BW'(DATA_BITS - 1)) state_nx = STOP;
            end
         end
         STOP:
            if (decide) begin
               state_nx = maj ? IDLE : BREAK;
               ready_nx = maj;
               err_nx   = !maj;
               data_nx  = maj ? shift : rxd_data;
            end
         BREAK:
            if (sync2) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // line synchroniser, edge history and all receiver state
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sync1          <= 1'b1;
         sync2          <= 1'b1;
         prev           <= 1'b1;
         state          <= IDLE;
         samp_cnt       <= '0;
         bit_cnt        <= '0;
         shift          <= '0;
         votes          <= '0;
         rxd_data       <= '0;
         rxd_data_ready <= 1'b0;
         rxd_frame_err  <= 1'b0;
      end else begin
         sync1          <= rxd;
         sync2          <= sync1;
         prev           <= sync2;
         state          <= state_nx;
         samp_cnt       <= samp_cnt_nx;
         bit_cnt        <= bit_cnt_nx;
         shift          <= shift_nx;
         votes          <= votes_nx;
         rxd_data       <= data_nx;
         rxd_data_ready <= ready_nx;
         rxd_frame_err  <= err_nx;
      end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed and randomized frames checked against a byte-level model of the receiver
module tb_uart_rx_oversample;
   localparam int CPB = 32;
   logic clk = 1'b0, reset = 1'b1, rxd = 1'b1;
   logic [7:0] rxd_data;
   logic rxd_data_ready, rxd_frame_err, rxd_busy;
   int n_chk = 0, n_pass = 0, cyc = 0, n_err = 0, n_both = 0, exp_err = 0;
   logic [7:0] got[$];
   int got_cyc[$];
   logic [7:0] exp_q[$];
   logic [7:0] last_good = 8'h00;

   uart_rx_oversample #(.CLK_FREQ(32000000), .BAUD(1000000), .OVERSAMPLE(16)) dut (
      .clk(clk),
      .reset(reset),
      .rxd(rxd),
      .rxd_data(rxd_data),
      .rxd_data_ready(rxd_data_ready),
      .rxd_frame_err(rxd_frame_err),
      .rxd_busy(rxd_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // record every output pulse away from the active edge
   always @(negedge clk) begin
      if (rxd_data_ready) begin
         got.push_back(rxd_data);
         got_cyc.push_back(cyc);
      end
      if (rxd_frame_err) n_err++;
      if (rxd_data_ready && rxd_frame_err) n_both++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at 2 ms, required to finish");
      $fatal(1);
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input logic spike, input int limit, output int t0);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      t0 = cyc;
      for (int i = 0; i < 10 * CPB && i < limit; i++) begin
         rxd = (spike && i % CPB == CPB / 2) ? ~f[i / CPB] : f[i / CPB];
         @(posedge clk); #1;
      end
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back(b);
      last_good = b;
   endtask

   task automatic verify(input string tag);
      check({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), int'(got[i]), int'(exp_q[i]));
      check({tag, "_errs"}, n_err, exp_err);
      check({tag, "_hold"}, int'(rxd_data), int'(last_good));
      got.delete();
      got_cyc.delete();
      exp_q.delete();
      n_err = 0;
      exp_err = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"}, int'(rxd_data), 0);
      check({tag, "_ready"}, int'(rxd_data_ready), 0);
      check({tag, "_err"}, int'(rxd_frame_err), 0);
      check({tag, "_busy"}, int'(rxd_busy), 0);
   endtask

   initial begin
      int t0, lat, k, gap;
      logic [7:0] b;
      logic stop, spike;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      reset = 1'b1;
      idle(10);

      send(8'hA5, 1'b1, 1'b0, 1000, t0);
      idle(40);
      lat = (got_cyc.size() > 0) ? got_cyc[0] - t0 : -1;
      check("a5_latency", (lat >= 307 && lat <= 311) ? 309 : lat, 309);
      expect_byte(8'hA5);
      verify("single");

      send(8'h00, 1'b1, 1'b0, 1000, t0);
      send(8'hFF, 1'b1, 1'b0, 1000, t0);
      send(8'h55, 1'b1, 1'b0, 1000, t0);
      idle(40);
      expect_byte(8'h00);
      expect_byte(8'hFF);
      expect_byte(8'h55);
      verify("b2b");

      rxd = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      rxd = 1'b1;
      check("glitch_busy_rise", int'(rxd_busy), 1);
      k = 0;
      while (rxd_busy && k < 20) begin @(posedge clk); #1; k++; end
      check("glitch_busy_fall", int'(rxd_busy), 0);
      idle(40);
      verify("glitch");

      send(8'h3C, 1'b0, 1'b0, 1000, t0);
      rxd = 1'b0;
      repeat (5 * CPB) begin @(posedge clk); #1; end
      idle(40);
      exp_err = 1;
      verify("ferr");
      send(8'h81, 1'b1, 1'b0, 1000, t0);
      idle(40);
      expect_byte(8'h81);
      verify("after_ferr");

      send(8'h96, 1'b1, 1'b1, 1000, t0);
      idle(40);
      expect_byte(8'h96);
      verify("noise");

      send(8'hC3, 1'b1, 1'b0, 5 * CPB + 16, t0);
      reset = 1'b0;
      #2;
      check_reset_outputs("midrst_a");
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("midrst_b");
      last_good = 8'h00;
      reset = 1'b1;
      idle(10);
      send(8'h7E, 1'b1, 1'b0, 1000, t0);
      idle(40);
      expect_byte(8'h7E);
      verify("midrst");

      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         spike = 1'($urandom_range(0, 1));
         gap = $urandom_range(0, 40);
         send(b, stop, spike, 1000, t0);
         if (stop) begin
            expect_byte(b);
            idle(gap);
         end else begin
            exp_err++;
            rxd = 1'b0;
            repeat (CPB) begin @(posedge clk); #1; end
            idle(40 + gap);
         end
      end
      idle(60);
      verify("rand");

      check("end_busy", int'(rxd_busy), 0);
      check("no_overlap", n_both, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
UART receiver that deserialises the asynchronous serial input into bytes for cmd_parser, driving its rxd_data / rxd_data_ready inputs. It oversamples the line, majority-votes each bit and rejects start-bit glitches. It reports framing errors, so a corrupted byte never reaches the command/MD5 pipeline.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, serial bit rate
OVERSAMPLE, 16, samples per bit; must be even and at least 8
TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE), derived localparam, clocks per sample tick, integer truncation, minimum 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
rxd  in  1  raw serial line, idle high, 8N1, LSB first
rxd_data  out  8  last correctly framed byte
rxd_data_ready  out  1  one-cycle pulse; rxd_data is valid in that cycle
rxd_frame_err  out  1  one-cycle pulse when the stop bit samples low
rxd_busy  out  1  high while a frame is being received (state != IDLE)

Behaviour:
- Reset values (reset=0, asynchronous): rxd_data=8'h00, rxd_data_ready=0, rxd_frame_err=0, rxd_busy=0, state=IDLE, synchroniser flops=1, counters=0.
- Input path: rxd goes through a 2-flop synchroniser, then one history flop for edge detection. All decisions use the synchronised signal.
- Tick: the divider counts 0..TICK_DIV-1 and pulses tick on wrap. The divider is held at 0 in IDLE and restarts on start-edge detection, so the sample phase is aligned to the edge.
- samp_cnt (0..OVERSAMPLE-1) advances per tick. The bit value is the majority of the samples at indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- States:
  - IDLE: on a synchronised falling edge (prev=1, cur=0), go to START and clear samp_cnt and bit_cnt.
  - START: at samp_cnt=OVERSAMPLE/2+1, if the majority is 1 (glitch), return to IDLE with no outputs. Otherwise continue to the end of the bit, then go to DATA.
  - DATA: 8 bits, shifted in LSB first into a shift register. bit_cnt is 0..7; after bit 7 completes, go to STOP.
  - STOP: evaluate the stop bit at samp_cnt=OVERSAMPLE/2+1 (mid-bit, not end of bit, so back-to-back frames are not missed).
    - If 1: load rxd_data from the shift register, pulse rxd_data_ready for 1 cycle, go to IDLE.
    - If 0: pulse rxd_frame_err, leave rxd_data unchanged, go to BREAK.
  - BREAK: wait until the synchronised line is 1, then go to IDLE (no byte is emitted during a break condition).
- rxd_data holds its value between frames. There is no FIFO: the consumer must take the byte in the ready cycle.
- rxd_data_ready and rxd_frame_err are never asserted in the same cycle.
- Latency, from the rxd falling edge to the ready pulse: 3 + (9*OVERSAMPLE + OVERSAMPLE/2 + 1)*TICK_DIV clocks, ±TICK_DIV.
- A new start edge arriving during the second half of the stop bit is accepted as soon as STOP exits to IDLE.
- Reset mid-frame: the partial byte is discarded, no pulse is produced, and the block starts in IDLE after reset releases.
- If rxd is held low from reset release, no frame is started until a 1→0 edge is seen.

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE/START/DATA/STOP/BREAK (3 bits)
  - DATA_BITS=8
  - a function computing TICK_DIV with a floor of 1
- One sub-module, uart_baud_tick: TICK_DIV counter with a synchronous restart input and a tick output. It is reused later by the uart_tx side.

Test Plan:
Common setup: CLK_FREQ=32000000, BAUD=1000000, OVERSAMPLE=16, giving TICK_DIV=2 and 32 clocks per bit.
- Single byte: send 0xA5 framed 8N1 → exactly one rxd_data_ready pulse with rxd_data=8'hA5, at 3+(144+9)*2=309 clocks ±2 after the start edge; rxd_frame_err never asserts.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap → three ready pulses carrying 00, FF, 55 in order; no frame errors.
- Glitch rejection: drive rxd low for 6 clocks, then high → stays in IDLE; no ready pulse, no error pulse; rxd_busy falls within 20 clocks.
- Framing error: send 0x3C with the stop bit low, then hold the line low for 5 bit times, then release, then send 0x81 → one rxd_frame_err pulse; rxd_data stays at its prior value; then one ready pulse with 8'h81.
- Noise tolerance: send 0x96 with a 1-clock inverted spike at the exact centre sample of every bit → rxd_data=8'h96 (majority vote).
- Reset mid-frame: assert reset during data bit 4 of 0xC3, release, then send 0x7E → no pulse for the aborted frame; all outputs at reset values while reset=0; then one ready pulse with 8'h7E.
